// File: rtl/cache_arb_pkg.sv
// ---------------------------------------------------------------------------
// cache_arb_pkg : shared types and default widths for cache_req_arbiter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cache_arb_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // One requester's payload at the default cache port widths.
  typedef struct packed {
    logic                  rw;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin selector, first valid at/after ptr
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && valid[j]) begin
        grant[j] = 1'b1;
        idx      = IW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// cache_req_arbiter : round-robin share of one cache controller port, one
// transaction in flight. Optional WAIT timeout via CACHE_ARB_TIMEOUT_EN.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cache_req_arbiter
  import cache_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_rw,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      Ejecute,
  output logic                      Lectura_Escritura,
  output logic [ADDR_W-1:0]         Direccion,
  output logic [DATA_W-1:0]         Dato_Entrada,
  input  logic                      Dato_Listo,
  input  logic [DATA_W-1:0]         Dato_Salida
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state;
  logic [IW-1:0]    ptr;
  logic [N_REQ-1:0] gsel;
  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [IW-1:0]    ptr_next;
  logic             tmo_hit;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign ptr_next = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt;

  // Counts completed WAIT cycles; hits on the last allowed one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_cnt <= '0;
    end else if (state == ISSUE) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  assign tmo_hit = (state == WAIT) && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
`else
  // No timeout: WAIT is left only on Dato_Listo, so this is constant false.
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state             <= IDLE;
      ptr               <= '0;
      gsel              <= '0;
      req_ready         <= '0;
      rsp_valid         <= '0;
      rsp_rdata         <= '0;
      rsp_err           <= 1'b0;
      Ejecute           <= 1'b0;
      Lectura_Escritura <= 1'b0;
      Direccion         <= '0;
      Dato_Entrada      <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      Ejecute   <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            req_ready         <= pick_grant;
            gsel              <= pick_grant;
            Lectura_Escritura <= req_rw[pick_idx];
            Direccion         <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            Dato_Entrada      <= req_wdata[pick_idx*DATA_W +: DATA_W];
            ptr               <= ptr_next;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          Ejecute <= 1'b1;
          state   <= WAIT;
        end
        WAIT: begin
          // A completion on the expiry cycle takes priority over the timeout.
          if (Dato_Listo) begin
            rsp_valid <= gsel;
            rsp_rdata <= Lectura_Escritura ? Dato_Salida : '0;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else if (tmo_hit) begin
            rsp_valid <= gsel;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_rdata         <= '0;
          rsp_err           <= 1'b0;
          Lectura_Escritura <= 1'b0;
          Direccion         <= '0;
          Dato_Entrada      <= '0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_req_arbiter : directed table-driven bench for cache_req_arbiter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cache_req_arbiter;
  import cache_arb_pkg::*;

  localparam int N_REQ  = 2;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;
  localparam int TMO    = 16;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_rw;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;
  logic                    rsp_err;
  logic                    Ejecute;
  logic                    Lectura_Escritura;
  logic [ADDR_W-1:0]       Direccion;
  logic [DATA_W-1:0]       Dato_Entrada;
  logic                    Dato_Listo;
  logic [DATA_W-1:0]       Dato_Salida;

  int tests = 0;
  int fails = 0;

  cache_req_arbiter #(
    .N_REQ       (N_REQ),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .CLK               (CLK),
    .RST               (RST),
    .req_valid         (req_valid),
    .req_rw            (req_rw),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .Ejecute           (Ejecute),
    .Lectura_Escritura (Lectura_Escritura),
    .Direccion         (Direccion),
    .Dato_Entrada      (Dato_Entrada),
    .Dato_Listo        (Dato_Listo),
    .Dato_Salida       (Dato_Salida)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] valid;
    req_t       r0;
    req_t       r1;
    int         delay;      // cycles from Ejecute to Dato_Listo (>= 2)
    logic [7:0] sal;        // Dato_Salida presented with Dato_Listo
    logic [1:0] exp_grant;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    req_t g;
    int   n;
    req_valid = v.valid;
    req_rw    = {v.r1.rw, v.r0.rw};
    req_addr  = {v.r1.addr, v.r0.addr};
    req_wdata = {v.r1.wdata, v.r0.wdata};
    g = v.exp_grant[1] ? v.r1 : v.r0;
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ready == '0 && n < 20);
    chk($sformatf("v%0d req_ready", id), 32'(req_ready), 32'(v.exp_grant));
    tick();
    chk($sformatf("v%0d ejecute", id), 32'(Ejecute), 32'd1);
    chk($sformatf("v%0d ready_pulse", id), 32'(req_ready), 32'd0);
    chk($sformatf("v%0d rw", id), 32'(Lectura_Escritura), 32'(g.rw));
    chk($sformatf("v%0d addr", id), 32'(Direccion), 32'(g.addr));
    chk($sformatf("v%0d wdata", id), 32'(Dato_Entrada), 32'(g.wdata));
    tick();
    chk($sformatf("v%0d ejecute_pulse", id), 32'(Ejecute), 32'd0);
    for (int i = 1; i < v.delay; i++) tick();
    chk($sformatf("v%0d early_rsp", id), 32'(rsp_valid), 32'd0);
    Dato_Listo  = 1'b1;
    Dato_Salida = v.sal;
    tick();
    Dato_Listo  = 1'b0;
    Dato_Salida = 8'hee;
    chk($sformatf("v%0d rsp_valid", id), 32'(rsp_valid), 32'(v.exp_grant));
    chk($sformatf("v%0d rsp_rdata", id), 32'(rsp_rdata), 32'(v.exp_rdata));
    chk($sformatf("v%0d rsp_err", id), 32'(rsp_err), 32'd0);
    chk($sformatf("v%0d addr_held", id), 32'(Direccion), 32'(g.addr));
    tick();
    chk($sformatf("v%0d rsp_pulse", id), 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Two held requesters: strict alternation from pointer 0.
    vecs[0] = '{2'b11, '{1'b1, 24'h000002, 8'h00}, '{1'b1, 24'h000003, 8'h00}, 2, 8'h11, 2'b01, 8'h11};
    vecs[1] = '{2'b11, '{1'b1, 24'h000002, 8'h00}, '{1'b1, 24'h000003, 8'h00}, 2, 8'h22, 2'b10, 8'h22};
    vecs[2] = '{2'b11, '{1'b1, 24'h000002, 8'h00}, '{1'b1, 24'h000003, 8'h00}, 3, 8'h33, 2'b01, 8'h33};
    vecs[3] = '{2'b11, '{1'b1, 24'h000002, 8'h00}, '{1'b1, 24'h000003, 8'h00}, 2, 8'h44, 2'b10, 8'h44};
    // Write captures 0 regardless of Dato_Salida.
    vecs[4] = '{2'b01, '{1'b0, 24'h000001, 8'haa}, '{1'b0, 24'h000000, 8'h00}, 2, 8'h5a, 2'b01, 8'h00};
    vecs[5] = '{2'b10, '{1'b0, 24'h000000, 8'h00}, '{1'b1, 24'h000001, 8'h00}, 6, 8'haa, 2'b10, 8'haa};
    vecs[6] = '{2'b11, '{1'b0, 24'h123456, 8'h3c}, '{1'b1, 24'habcdef, 8'h99}, 3, 8'h77, 2'b01, 8'h00};
    vecs[7] = '{2'b11, '{1'b0, 24'h123456, 8'h3c}, '{1'b1, 24'habcdef, 8'h99}, 2, 8'hc3, 2'b10, 8'hc3};
    vecs[8] = '{2'b10, '{1'b0, 24'h000000, 8'h00}, '{1'b1, 24'hfedcba, 8'h00}, 4, 8'h0f, 2'b10, 8'h0f};

    RST         = 1'b1;
    req_valid   = 2'b11;
    req_rw      = 2'b11;
    req_addr    = {24'h000003, 24'h000002};
    req_wdata   = 16'h1234;
    Dato_Listo  = 1'b0;
    Dato_Salida = 8'h00;
    tick();
    tick();
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst rsp", 32'({rsp_valid, rsp_rdata, rsp_err}), 32'd0);
    chk("rst cache_ctl", 32'({Ejecute, Lectura_Escritura, Dato_Entrada}), 32'd0);
    chk("rst addr", 32'(Direccion), 32'd0);
    RST = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset while waiting on the cache: abort, no response, late Dato_Listo ignored.
    req_valid = 2'b01;
    req_rw    = 2'b01;
    req_addr  = {24'h000000, 24'h0000ff};
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ready == '0 && n < 20);
    chk("abort grant", 32'(req_ready), 32'd1);
    tick();
    tick();
    RST = 1'b1;
    tick();
    RST       = 1'b0;
    req_valid = 2'b00;
    chk("abort outputs", 32'({rsp_valid, Ejecute, Lectura_Escritura, Direccion}), 32'd0);
    Dato_Listo  = 1'b1;
    Dato_Salida = 8'h66;
    tick();
    Dato_Listo = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid != '0 || Ejecute != 1'b0) n++;
    end
    chk("abort quiet", 32'(n), 32'd0);
    // Pointer restarts at 0 after reset.
    run_vec(vecs[0], 9);

    // Cache never answers.
    req_valid = 2'b10;
    req_rw    = 2'b00;
    req_addr  = {24'h000010, 24'h000000};
    req_wdata = {8'h55, 8'h00};
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ready == '0 && n < 20);
    chk("tmo grant", 32'(req_ready), 32'd2);
    req_valid = 2'b00;
    n = 0;
    while (rsp_valid == '0 && n < 100) begin
      tick();
      n++;
    end
`ifdef CACHE_ARB_TIMEOUT_EN
    chk("tmo cycles", 32'(n), 32'd17);
    chk("tmo rsp_valid", 32'(rsp_valid), 32'd2);
    chk("tmo rsp_err", 32'(rsp_err), 32'd1);
    chk("tmo rsp_rdata", 32'(rsp_rdata), 32'd0);
`else
    chk("no_tmo still_waiting", 32'(rsp_valid), 32'd0);
    Dato_Listo  = 1'b1;
    Dato_Salida = 8'h77;
    tick();
    Dato_Listo = 1'b0;
    chk("no_tmo late rsp_valid", 32'(rsp_valid), 32'd2);
    chk("no_tmo late rsp_err", 32'(rsp_err), 32'd0);
    chk("no_tmo late rdata", 32'(rsp_rdata), 32'd0);
`endif
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
